// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: Wishbone-slave sequencer for the Fibonacci engine.
// Firmware loads a step count N and writes start. The block clears the engine,
// issues N step cycles (stopping early on engine overflow), captures F(N) into
// RESULT and raises done / irq. Abort returns to IDLE without capturing.
module fib_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIDTH     = 32,
  parameter int          CNT_W     = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             eng_clear,
  output logic             eng_step,
  input  logic [WIDTH-1:0] eng_value,
  input  logic             eng_ovf,
  output logic             busy,
  output logic             irq
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q;
  logic               irq_en_q, done_q, ovf_q, aborted_q;

  // Bus request captured at the request edge and acted on in the ack cycle
  logic               ack_q, we_q;
  logic [1:0]         reg_q;
  logic [15:0]        wdat_q;
  logic [1:0]         wsel_q;
  logic [31:0]        rdat_q;
  logic [31:0]        rd_mux;

  logic addr_hit, req, wr, wr_ctrl, wr_count, wr_stat;
  logic idle, start_go, abort_go;
  logic step_c, capture_c, set_ovf_c;
  logic unused_ok;

  assign addr_hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  // ack low in the request condition forbids back-to-back acks
  assign req      = wbs_stb_i & wbs_cyc_i & addr_hit & ~ack_q;

  assign idle     = (state_q == S_IDLE);
  assign wr       = ack_q & we_q;
  assign wr_ctrl  = wr & (reg_q == 2'd0) & wsel_q[0];
  assign wr_count = wr & (reg_q == 2'd1) & (|wsel_q);
  assign wr_stat  = wr & (reg_q == 2'd2) & wsel_q[0];
  // Abort dominates start in the same write; each only acts in its own state
  assign abort_go = wr_ctrl & wdat_q[1] & ~idle;
  assign start_go = wr_ctrl & wdat_q[0] & ~wdat_q[1] & idle;

  assign unused_ok = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i[31:16]};

  // Read data source for the addressed register
  always_comb begin
    rd_mux = 32'd0;
    case (wbs_adr_i[3:2])
      2'd0:    rd_mux = {29'd0, irq_en_q, 2'b00};
      2'd1:    rd_mux = 32'(count_q);
      2'd2:    rd_mux = {28'd0, aborted_q, ovf_q, done_q, ~idle};
      default: rd_mux = 32'(result_q);
    endcase
  end

  // Wishbone handshake: one-cycle ack with registered read data, 0 otherwise
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q  <= 1'b0;
      we_q   <= 1'b0;
      reg_q  <= 2'd0;
      wdat_q <= 16'd0;
      wsel_q <= 2'd0;
      rdat_q <= 32'd0;
    end else begin
      ack_q <= req;
      if (req) begin
        we_q   <= wbs_we_i;
        reg_q  <= wbs_adr_i[3:2];
        wdat_q <= wbs_dat_i[15:0];
        wsel_q <= wbs_sel_i[1:0];
        rdat_q <= wbs_we_i ? 32'd0 : rd_mux;
      end else begin
        rdat_q <= 32'd0;
      end
    end
  end

  // COUNT write merge: byte 0 and byte 1 lanes honour their selects
  always_comb begin
    logic [31:0] merged;
    merged = 32'(count_q);
    if (wsel_q[0]) merged[7:0]  = wdat_q[7:0];
    if (wsel_q[1]) merged[15:8] = wdat_q[15:8];
    count_d = merged[CNT_W-1:0];
  end

  // Sequencer next state, step counter and engine strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_c    = 1'b0;
    capture_c = 1'b0;
    set_ovf_c = 1'b0;
    case (state_q)
      S_IDLE: if (start_go) state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_d   = count_q;
        state_d = (count_q == '0) ? S_CAPTURE : S_RUN;
      end
      S_RUN: begin
        if (eng_ovf) begin
          set_ovf_c = 1'b1;
          state_d   = S_CAPTURE;
        end else if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          step_c = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          // Leave on the last step so F(N) is on eng_value during CAPTURE
          if (cnt_q == CNT_W'(1)) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture_c = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_go) begin
      state_d   = S_IDLE;
      capture_c = 1'b0;
      set_ovf_c = 1'b0;
    end
  end

  // Sequencer state and step counter registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Software-visible registers; hardware set events override W1C clears
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      count_q   <= '0;
      result_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wdat_q[2];
      if (wr_count && idle) count_q <= count_d;
      if (start_go) begin
        done_q    <= 1'b0;
        ovf_q     <= 1'b0;
        aborted_q <= 1'b0;
      end
      if (wr_stat) begin
        if (wdat_q[1]) done_q    <= 1'b0;
        if (wdat_q[2]) ovf_q     <= 1'b0;
        if (wdat_q[3]) aborted_q <= 1'b0;
      end
      if (capture_c) begin
        result_q <= eng_value;
        done_q   <= 1'b1;
      end
      if (set_ovf_c) ovf_q <= 1'b1;
      if (abort_go) begin
        aborted_q <= 1'b1;
        done_q    <= 1'b0;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdat_q;
  assign eng_clear = (state_q == S_CLEAR);
  assign eng_step  = step_c;
  assign busy      = ~idle;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed bench with a mock 16-bit Fibonacci engine.
// Read expectations are queued at issue time and checked by a monitor on ack.
module tb_fib_seq_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stb, cyc, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack;
  logic [31:0]   rdat;
  logic          eng_clear, eng_step, eng_ovf, busy, irq;
  logic [W-1:0]  eng_value;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int clear_cnt = 0;
  int step_cnt  = 0;

  logic [31:0] fa = 32'd0;
  logic [31:0] fb = 32'd1;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_e;
  string       mon_n;

  always #5 clk = ~clk;

  fib_seq_ctrl #(.BASE_ADDR(BASE), .WIDTH(W), .CNT_W(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .eng_clear(eng_clear),
    .eng_step (eng_step),
    .eng_value(eng_value),
    .eng_ovf  (eng_ovf),
    .busy     (busy),
    .irq      (irq)
  );

  // Mock engine: value fa = F(k), fb = F(k+1); overflow when F(k+1) exceeds 16 bits
  always @(posedge clk) begin
    if (eng_clear) begin
      fa <= 32'd0;
      fb <= 32'd1;
    end else if (eng_step) begin
      fa <= fb;
      fb <= fa + fb;
    end
  end
  assign eng_value = fa[W-1:0];
  assign eng_ovf   = (fb > 32'd65535);

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (eng_clear) clear_cnt++;
    if (eng_step)  step_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read ack pops one expectation
  always @(posedge clk) begin
    #1;
    if (ack && !we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read_ack", rdat, 32'hDEAD_BEEF);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        chk(mon_n, rdat, mon_e);
      end
    end
  end

  task automatic wb_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input bit hold, output int t);
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; stb = 1'b1; cyc = 1'b1;
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        t = cyc_n;
        break;
      end
    end
    if (t < 0) chk("ack_timeout", {31'd0, ack}, 32'd1);
    else if (hold) begin
      @(posedge clk); #1;
      chk("ack_single_pulse", {31'd0, ack}, 32'd0);
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    $display("wb %s adr=0x%08h dat=0x%08h ack_cycle=%0d", w ? "wr" : "rd", a, d, t);
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s, output int t);
    wb_access(BASE + 32'(idx * 4), 1'b1, d, s, 1'b0, t);
  endtask

  task automatic rd(input int idx, input logic [31:0] e, input string name, input bit hold);
    int t;
    exp_q.push_back(e);
    name_q.push_back(name);
    wb_access(BASE + 32'(idx * 4), 1'b0, 32'd0, 4'hF, hold, t);
  endtask

  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        c = cyc_n;
        break;
      end
    end
    if (c < 0) chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t, c, c0, s0, acks;
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'd0; wdat = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_clear", {31'd0, eng_clear}, 32'd0);
    chk("rst_step", {31'd0, eng_step}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;

    // Reset values, each read checked for a single-cycle ack
    rd(0, 32'd0, "rst_ctrl", 1'b1);
    rd(1, 32'd0, "rst_count", 1'b1);
    rd(2, 32'd0, "rst_status", 1'b1);
    rd(3, 32'd0, "rst_result", 1'b1);

    // N=10: one clear, ten steps, done at t+13, F(10)=55
    wr(1, 32'd10, 4'b0011, t);
    c0 = clear_cnt; s0 = step_cnt;
    wr(0, 32'h1, 4'b0001, t);
    wait_idle(c);
    chk("n10_done_latency", 32'(c - t), 32'd13);
    chk("n10_clears", 32'(clear_cnt - c0), 32'd1);
    chk("n10_steps", 32'(step_cnt - s0), 32'd10);
    chk("n10_irq", {31'd0, irq}, 32'd0);
    rd(3, 32'd55, "n10_result", 1'b0);
    rd(2, 32'h2, "n10_status", 1'b0);

    // N=1000 aborted after about 5 steps; start and COUNT writes while busy ignored
    wr(1, 32'd1000, 4'b0011, t);
    c0 = clear_cnt; s0 = step_cnt;
    wr(0, 32'h1, 4'b0001, t);
    for (int i = 0; i < 50 && (step_cnt - s0) < 5; i++) @(negedge clk);
    wr(0, 32'h1, 4'b0001, t);
    wr(1, 32'd7, 4'b0011, t);
    wr(0, 32'h2, 4'b0001, t);
    @(negedge clk);
    chk("abort_step_dropped", {31'd0, eng_step}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_clears", 32'(clear_cnt - c0), 32'd1);
    rd(2, 32'h8, "abort_status", 1'b0);
    rd(3, 32'd55, "abort_result", 1'b0);
    rd(1, 32'd1000, "busy_count_write_ignored", 1'b0);

    // N=0: clear pulse, no step, done at t+3, RESULT=F(0)
    wr(1, 32'd0, 4'b0011, t);
    c0 = clear_cnt; s0 = step_cnt;
    wr(0, 32'h1, 4'b0001, t);
    wait_idle(c);
    chk("n0_done_latency", 32'(c - t), 32'd3);
    chk("n0_clears", 32'(clear_cnt - c0), 32'd1);
    chk("n0_steps", 32'(step_cnt - s0), 32'd0);
    rd(3, 32'd0, "n0_result", 1'b0);
    rd(2, 32'h2, "n0_status", 1'b0);

    // N=30 with irq enabled: stops at F(24)=46368 on overflow
    wr(0, 32'h4, 4'b0001, t);
    wr(1, 32'd30, 4'b0011, t);
    s0 = step_cnt;
    wr(0, 32'h5, 4'b0001, t);
    wait_idle(c);
    chk("ovf_steps", 32'(step_cnt - s0), 32'd24);
    chk("ovf_irq", {31'd0, irq}, 32'd1);
    rd(3, 32'd46368, "ovf_result", 1'b0);
    rd(2, 32'h6, "ovf_status", 1'b0);
    rd(0, 32'h4, "ovf_ctrl", 1'b0);
    wr(2, 32'h2, 4'b0001, t);
    @(negedge clk);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    rd(2, 32'h4, "w1c_status", 1'b0);

    // Unmatched address: no ack, read data stays 0
    @(negedge clk);
    adr = BASE + 32'h10; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) acks++;
      if (rdat != 32'd0) acks += 100;
    end
    chk("unmatched_no_ack", 32'(acks), 32'd0);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    $display("wb rd adr=0x%08h unmatched probe acks=%0d", BASE + 32'h10, acks);

    // Async reset mid-RUN: engine controls and busy drop without a clock edge
    wr(1, 32'd100, 4'b0011, t);
    wr(0, 32'h1, 4'b0001, t);
    repeat (5) @(negedge clk);
    chk("pre_reset_step", {31'd0, eng_step}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_step", {31'd0, eng_step}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_clear", {31'd0, eng_clear}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(3, 32'd0, "post_rst_result", 1'b0);
    rd(2, 32'd0, "post_rst_status", 1'b0);
    rd(1, 32'd0, "post_rst_count", 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
